colormap_rom_arbiter: RTL and testbench

Shares one synchronous colormap ROM (24-bit RGB, 256 entries) between two independent lookup requesters:
- Port 0: the live thermal-pixel video path.
- Port 1: the scale-bar/legend renderer.

Each port has a valid/ready request channel and a valid/ready response channel with a 2-entry response buffer. One ROM read is issued per cycle, and each port sustains one lookup per cycle when uncontested. The block sits between the temperature-normalisation stage and the display compositor, and owns the only ROM instance.

---
 rtl/colormap_pkg.sv | 7 +
 rtl/colormap_rom_arbiter_rsp_fifo2.sv | 41 ++++
 rtl/rom_sync.sv | 13 +
 rtl/colormap_rom_arbiter.sv | 79 +++++++
 tb/tb_colormap_rom_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/colormap_pkg.sv
// colormap_pkg: shared types and constants for the colormap ROM arbiter
package colormap_pkg;
    localparam int NPORTS = 2;
    localparam int OCCW   = 2;
    typedef logic        port_id_t;
    typedef logic [23:0] rgb_t;
endpackage

// File: rtl/colormap_rom_arbiter_rsp_fifo2.sv
// rsp_fifo2: two-entry register FIFO whose head is always a register
module rsp_fifo2
    import colormap_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [OCCW-1:0]  count_o
);
    logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [OCCW-1:0]  count_q, count_d, wpos;

    // A pop shifts the tail into the head; a push lands in the first slot free after that pop.
    always_comb begin
        wpos    = count_q - OCCW'(pop_i);
        e0_d    = (push_i && wpos == '0) ? data_i : (pop_i ? e1_q : e0_q);
        e1_d    = (push_i && wpos == OCCW'(1)) ? data_i : e1_q;
        count_d = count_q + OCCW'(push_i) - OCCW'(pop_i);
    end

    // Entry and count registers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= '0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = e0_q;
    assign count_o = count_q;
endmodule

// File: rtl/rom_sync.sv
// rom_sync: synchronous-read ROM with a registered output holding entry k = {k, ~k, k}
module rom_sync #(
  parameter int    WIDTH  = 24,
  parameter int    DEPTH  = 256,
  parameter string INIT_F = "",
  localparam int   ADDRW  = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic [ADDRW-1:0] addr_i,
  output logic [WIDTH-1:0] data_o
);
  always_ff @(posedge clk_i) data_o <= WIDTH'({addr_i, ~addr_i, addr_i});
endmodule

// File: rtl/colormap_rom_arbiter.sv
// colormap_rom_arbiter: two lookup ports sharing one synchronous colormap ROM
module colormap_rom_arbiter
    import colormap_pkg::*;
#(
    parameter int    WIDTH      = 24,
    parameter int    DEPTH      = 256,
    parameter string INIT_F     = "turbo_colormap.hex",
    parameter bit    FIXED_PRIO = 1'b0,
    localparam int   ADDRW      = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NPORTS-1:0]            req_valid,
    input  logic [NPORTS-1:0][ADDRW-1:0] req_addr,
    output logic [NPORTS-1:0]            req_ready,
    output logic [NPORTS-1:0]            rsp_valid,
    output logic [NPORTS-1:0][WIDTH-1:0] rsp_data,
    input  logic [NPORTS-1:0]            rsp_ready,
    output logic                         busy
);
    logic [NPORTS-1:0]           elig, push, pop;
    logic [NPORTS-1:0][OCCW-1:0] count, occ;
    logic [ADDRW-1:0]            addr_q, addr_d;
    logic [WIDTH-1:0]            rom_data;
    logic                        inflight_q, gnt_any;
    port_id_t                    tag_q, last_q, gnt_port;

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        // Occupancy counts the read in flight for this port plus its buffered entries.
        assign push[i]      = inflight_q && tag_q == port_id_t'(i);
        assign pop[i]       = rsp_valid[i] && rsp_ready[i];
        assign occ[i]       = count[i] + OCCW'(push[i]);
        assign elig[i]      = req_valid[i] && (occ[i] < OCCW'(2) || pop[i]);
        assign rsp_valid[i] = count[i] != '0;
        assign req_ready[i] = rst_n && gnt_any && gnt_port == port_id_t'(i);

        rsp_fifo2 #(.WIDTH(WIDTH)) u_fifo (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .push_i  (push[i]),
            .data_i  (rom_data),
            .pop_i   (pop[i]),
            .head_o  (rsp_data[i]),
            .count_o (count[i])
        );
    end

    // A lone eligible port wins; a tie goes to port 0 or to the port not served last.
    always_comb begin
        gnt_any  = |elig;
        gnt_port = (&elig) ? (FIXED_PRIO ? 1'b0 : ~last_q) : elig[1];
        addr_d   = gnt_any ? req_addr[gnt_port] : addr_q;
    end

    // In-flight tag, round-robin pointer and held ROM address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            tag_q      <= 1'b0;
            last_q     <= 1'b1;
            addr_q     <= '0;
        end else begin
            inflight_q <= gnt_any;
            addr_q     <= addr_d;
            if (gnt_any) begin
                tag_q  <= gnt_port;
                last_q <= gnt_port;
            end
        end
    end

    rom_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_F(INIT_F)) u_rom (
        .clk_i  (clk),
        .addr_i (addr_d),
        .data_o (rom_data)
    );

    assign busy = inflight_q || (|count[0]) || (|count[1]);
endmodule

// File: tb/tb_colormap_rom_arbiter.sv
// tb_colormap_rom_arbiter: directed checks of the shared colormap ROM arbiter
module tb_colormap_rom_arbiter;
    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0][7:0]  req_addr = '0;
    logic [1:0]       rsp_ready = '0;
    logic [1:0]       req_ready, rsp_valid;
    logic [1:0][23:0] rsp_data;
    logic             busy;
    logic [1:0]       fp_req_ready, fp_rsp_valid;
    logic [1:0][23:0] fp_rsp_data;
    logic             fp_busy;

    int checks = 0;
    int failures = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    colormap_rom_arbiter #(.WIDTH(24), .DEPTH(256), .INIT_F(""), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    colormap_rom_arbiter #(.WIDTH(24), .DEPTH(256), .INIT_F(""), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(fp_req_ready), .rsp_valid(fp_rsp_valid), .rsp_data(fp_rsp_data),
        .rsp_ready(rsp_ready), .busy(fp_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [23:0] exp_rgb(logic [7:0] k);
        return {k, ~k, k};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard the settled cycle, then advance to the next drive point.
    task automatic step();
        logic [7:0] a;
        if (rsp_valid[0] && rsp_ready[0]) begin
            if (q0.size() == 0) check("spurious_rsp0", 1, 0);
            else begin
                a = q0.pop_front();
                check("rsp_data0", rsp_data[0], exp_rgb(a));
            end
        end
        if (rsp_valid[1] && rsp_ready[1]) begin
            if (q1.size() == 0) check("spurious_rsp1", 1, 0);
            else begin
                a = q1.pop_front();
                check("rsp_data1", rsp_data[1], exp_rgb(a));
            end
        end
        if (req_valid[0] && req_ready[0]) q0.push_back(req_addr[0]);
        if (req_valid[1] && req_ready[1]) q1.push_back(req_addr[1]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        q0.delete();
        q1.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int first, last, n;
        logic [7:0] a0, a1;
        int p1_idx;
        logic [7:0] p1_addrs [3];
        logic [1:0] bp_exp [13];
        p1_addrs = '{8'h20, 8'h21, 8'h22};
        bp_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01,
                   2'b01, 2'b01, 2'b10, 2'b01, 2'b01};

        // Reset state, with requests already pending.
        #1;
        rst_n = 1'b0;
        req_valid = 2'b11;
        #2;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_fp_busy", fp_busy, 0);
        do_reset();

        // Single read on port 0.
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        req_addr[0] = 8'h10;
        #1;
        check("single_accept", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        #1;
        check("single_n1_valid", rsp_valid, 2'b00);
        check("single_n1_busy", busy, 1);
        step();
        #1;
        check("single_n2_valid", rsp_valid, 2'b01);
        check("single_n2_data", rsp_data[0], 24'h10EF10);
        step();
        #1;
        check("single_drained_valid", rsp_valid, 2'b00);
        check("single_drained_busy", busy, 0);

        // Streaming 0..255 on port 0.
        first = -1;
        last = -1;
        n = 0;
        for (int c = 0; c < 260; c++) begin
            req_valid = {1'b0, c < 256};
            req_addr[0] = 8'(c);
            #1;
            if (c < 256) check("stream_ready", req_ready[0], 1);
            if (rsp_valid[0]) begin
                if (first < 0) first = c;
                last = c;
                n++;
            end
            step();
        end
        check("stream_count", n, 256);
        check("stream_first", first, 2);
        check("stream_span", last - first, 255);
        check("stream_q_empty", q0.size(), 0);

        // Contention, round-robin versus fixed priority.
        do_reset();
        rsp_ready = 2'b11;
        a0 = 8'h40;
        a1 = 8'h80;
        for (int c = 0; c < 8; c++) begin
            req_valid = 2'b11;
            req_addr[0] = a0;
            req_addr[1] = a1;
            #1;
            check("rr_grant", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            check("fp_grant", fp_req_ready, 2'b01);
            if (c == 2) begin
                check("fp_rsp_valid", fp_rsp_valid[0], 1);
                check("fp_rsp_data", fp_rsp_data[0], 24'h40BF40);
            end
            if (req_ready[0]) a0++;
            if (req_ready[1]) a1++;
            step();
        end
        req_valid = 2'b00;
        for (int c = 0; c < 4; c++) step();
        check("rr_q0_empty", q0.size(), 0);
        check("rr_q1_empty", q1.size(), 0);

        // Backpressure on port 1 while port 0 streams.
        do_reset();
        rsp_ready = 2'b01;
        a0 = 8'h50;
        p1_idx = 0;
        for (int c = 0; c < 13; c++) begin
            if (c == 10) rsp_ready = 2'b11;
            req_valid = {p1_idx < 3, 1'b1};
            req_addr[0] = a0;
            req_addr[1] = p1_addrs[p1_idx < 3 ? p1_idx : 2];
            #1;
            check("bp_grant", req_ready, bp_exp[c]);
            if (c == 9) begin
                check("bp_held_valid", rsp_valid[1], 1);
                check("bp_held_data", rsp_data[1], 24'h20DF20);
            end
            if (c == 11) check("bp_second_data", rsp_data[1], 24'h21DE21);
            if (c == 12) check("bp_third_data", rsp_data[1], 24'h22DD22);
            if (req_ready[0]) a0++;
            if (req_ready[1]) p1_idx++;
            step();
        end
        req_valid = 2'b00;
        for (int c = 0; c < 4; c++) step();
        check("bp_q0_empty", q0.size(), 0);
        check("bp_q1_empty", q1.size(), 0);

        // Reset with a read in flight and responses buffered.
        rsp_ready = 2'b00;
        req_addr[0] = 8'h60;
        req_addr[1] = 8'h70;
        req_valid = 2'b11;
        for (int c = 0; c < 3; c++) step();
        req_valid = 2'b00;
        #1;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_valid", rsp_valid, 2'b11);
        rst_n = 1'b0;
        req_valid = 2'b11;
        q0.delete();
        q1.delete();
        #1;
        check("mid_rst_valid", rsp_valid, 2'b00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", req_ready, 2'b00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("post_rst_no_stale", rsp_valid, 2'b00);
            step();
        end
        req_valid = 2'b10;
        req_addr[1] = 8'hA5;
        #1;
        check("post_rst_accept", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        #1;
        check("post_rst_n1_valid", rsp_valid, 2'b00);
        step();
        #1;
        check("post_rst_n2_valid", rsp_valid, 2'b10);
        check("post_rst_data", rsp_data[1], 24'hA55AA5);
        step();
        #1;
        check("post_rst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
